// File: rtl/alu_share_arbiter_if.sv
// Requester/response handshake and ALU drive bundle for alu_share_arbiter.
// slave = arbiter side, master = requesters plus the ALU instance.
interface alu_share_arbiter_if #(
   parameter int DATA_W = 32
);
   logic              req0_valid;
   logic              req0_ready;
   logic [3:0]        req0_ctrl;
   logic [DATA_W-1:0] req0_op1;
   logic [DATA_W-1:0] req0_op2;
   logic [4:0]        req0_shamnt;
   logic              req1_valid;
   logic              req1_ready;
   logic [3:0]        req1_ctrl;
   logic [DATA_W-1:0] req1_op1;
   logic [DATA_W-1:0] req1_op2;
   logic [4:0]        req1_shamnt;
   logic              rsp0_valid;
   logic              rsp0_ready;
   logic              rsp1_valid;
   logic              rsp1_ready;
   logic [DATA_W-1:0] rsp_result;
   logic [7:0]        rsp_status;
   logic [3:0]        alu_ctrl;
   logic [DATA_W-1:0] alu_operand_1;
   logic [DATA_W-1:0] alu_operand_2;
   logic [4:0]        alu_shamnt;
   logic [DATA_W-1:0] alu_result;
   logic [7:0]        alu_status;

   modport slave (
      input  req0_valid, req0_ctrl, req0_op1, req0_op2, req0_shamnt,
      input  req1_valid, req1_ctrl, req1_op1, req1_op2, req1_shamnt,
      input  rsp0_ready, rsp1_ready, alu_result, alu_status,
      output req0_ready, req1_ready, rsp0_valid, rsp1_valid,
      output rsp_result, rsp_status,
      output alu_ctrl, alu_operand_1, alu_operand_2, alu_shamnt
   );

   modport master (
      output req0_valid, req0_ctrl, req0_op1, req0_op2, req0_shamnt,
      output req1_valid, req1_ctrl, req1_op1, req1_op2, req1_shamnt,
      output rsp0_ready, rsp1_ready, alu_result, alu_status,
      input  req0_ready, req1_ready, rsp0_valid, rsp1_valid,
      input  rsp_result, rsp_status,
      input  alu_ctrl, alu_operand_1, alu_operand_2, alu_shamnt
   );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one ALU between two requesters with settle-time hold.
// Optional macro ALU_ARB_DIV0_BYPASS_EN answers divide-by-zero without the ALU.
module alu_share_arbiter #(
   parameter int DATA_W        = 32,
   parameter int BASIC_SETTLE  = 1,
   parameter int MULDIV_SETTLE = 4
)(
   input  logic                clk,
   input  logic                rst,
   alu_share_arbiter_if.slave  bus,
   output logic                busy
);
   localparam int MAX_SETTLE = (MULDIV_SETTLE > BASIC_SETTLE) ? MULDIV_SETTLE : BASIC_SETTLE;
   localparam int CNT_W      = (MAX_SETTLE > 1) ? $clog2(MAX_SETTLE) : 1;
   localparam logic [CNT_W-1:0] BASIC_LAST  = CNT_W'(BASIC_SETTLE - 1);
   localparam logic [CNT_W-1:0] MULDIV_LAST = CNT_W'(MULDIV_SETTLE - 1);
   localparam logic [3:0] CTRL_IDLE = 4'b1111;
   localparam logic [3:0] CTRL_MUL  = 4'b1000;
   localparam logic [3:0] CTRL_DIV  = 4'b1001;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_RESP  = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_next_state;
   logic                r_owner;
   logic                r_last_grant;
   logic [CNT_W-1:0]    r_cnt;
   logic [3:0]          r_alu_ctrl;
   logic [DATA_W-1:0]   r_alu_op1;
   logic [DATA_W-1:0]   r_alu_op2;
   logic [4:0]          r_alu_shamnt;
   logic [DATA_W-1:0]   r_rsp_result;
   logic [7:0]          r_rsp_status;

   logic                w_grant;
   logic                w_accept;
   logic [3:0]          w_sel_ctrl;
   logic [DATA_W-1:0]   w_sel_op1;
   logic [DATA_W-1:0]   w_sel_op2;
   logic [4:0]          w_sel_shamnt;
   logic                w_div0_bypass;
   logic [CNT_W-1:0]    w_limit_last;
   logic                w_issue_done;
   logic                w_rsp_take;

   // Grant selection: lone valid port wins, a tie goes to the port not served last.
   always_comb begin
      w_grant = 1'b0;
      if (bus.req0_valid && bus.req1_valid) begin
         w_grant = ~r_last_grant;
      end else if (bus.req1_valid) begin
         w_grant = 1'b1;
      end else begin
         w_grant = 1'b0;
      end
   end

   assign w_accept     = (r_state == ST_IDLE) && (w_grant ? bus.req1_valid : bus.req0_valid);
   assign w_sel_ctrl   = w_grant ? bus.req1_ctrl   : bus.req0_ctrl;
   assign w_sel_op1    = w_grant ? bus.req1_op1    : bus.req0_op1;
   assign w_sel_op2    = w_grant ? bus.req1_op2    : bus.req0_op2;
   assign w_sel_shamnt = w_grant ? bus.req1_shamnt : bus.req0_shamnt;

`ifdef ALU_ARB_DIV0_BYPASS_EN
   assign w_div0_bypass = (w_sel_ctrl == CTRL_DIV) && (w_sel_op2 == {DATA_W{1'b0}});
`else
   assign w_div0_bypass = 1'b0;
`endif

   assign w_limit_last = ((r_alu_ctrl == CTRL_MUL) || (r_alu_ctrl == CTRL_DIV)) ? MULDIV_LAST : BASIC_LAST;
   assign w_issue_done = (r_cnt == w_limit_last);
   assign w_rsp_take   = (r_state == ST_RESP) && (r_owner ? bus.rsp1_ready : bus.rsp0_ready);

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               w_next_state = w_div0_bypass ? ST_RESP : ST_ISSUE;
            end else begin
               w_next_state = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            if (w_issue_done) begin
               w_next_state = ST_RESP;
            end else begin
               w_next_state = ST_ISSUE;
            end
         end
         ST_RESP: begin
            if (w_rsp_take) begin
               w_next_state = ST_IDLE;
            end else begin
               w_next_state = ST_RESP;
            end
         end
         default: w_next_state = ST_IDLE;
      endcase
   end

   // Handshake outputs decoded from state and owner.
   always_comb begin
      bus.req0_ready = 1'b0;
      bus.req1_ready = 1'b0;
      bus.rsp0_valid = 1'b0;
      bus.rsp1_valid = 1'b0;
      busy           = 1'b1;
      case (r_state)
         ST_IDLE: begin
            bus.req0_ready = ~w_grant;
            bus.req1_ready = w_grant;
            busy           = 1'b0;
         end
         ST_ISSUE: busy = 1'b1;
         ST_RESP: begin
            bus.rsp0_valid = ~r_owner;
            bus.rsp1_valid = r_owner;
         end
         default: busy = 1'b1;
      endcase
   end

   // Operand latch, settle counter and result capture.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_owner      <= 1'b0;
         r_last_grant <= 1'b1;
         r_cnt        <= {CNT_W{1'b0}};
         r_alu_ctrl   <= CTRL_IDLE;
         r_alu_op1    <= {DATA_W{1'b0}};
         r_alu_op2    <= {DATA_W{1'b0}};
         r_alu_shamnt <= 5'd0;
         r_rsp_result <= {DATA_W{1'b0}};
         r_rsp_status <= 8'h00;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_owner      <= w_grant;
                  r_last_grant <= w_grant;
                  r_cnt        <= {CNT_W{1'b0}};
                  if (w_div0_bypass) begin
                     // ALU stays parked; answer is synthesised locally.
                     r_rsp_result <= {DATA_W{1'b0}};
                     r_rsp_status <= 8'b1000_0100;
                  end else begin
                     r_alu_ctrl   <= w_sel_ctrl;
                     r_alu_op1    <= w_sel_op1;
                     r_alu_op2    <= w_sel_op2;
                     r_alu_shamnt <= w_sel_shamnt;
                  end
               end
            end
            ST_ISSUE: begin
               r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
               if (w_issue_done) begin
                  r_rsp_result <= bus.alu_result;
                  r_rsp_status <= bus.alu_status;
               end
            end
            ST_RESP: begin
               if (w_rsp_take) begin
                  r_alu_ctrl <= CTRL_IDLE;
               end
            end
            default: r_alu_ctrl <= CTRL_IDLE;
         endcase
      end
   end

   assign bus.alu_ctrl      = r_alu_ctrl;
   assign bus.alu_operand_1 = r_alu_op1;
   assign bus.alu_operand_2 = r_alu_op2;
   assign bus.alu_shamnt    = r_alu_shamnt;
   assign bus.rsp_result    = r_rsp_result;
   assign bus.rsp_status    = r_rsp_status;
endmodule
